// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that lets the fetch (imem) and load/store (dmem) ports
// share one SRAM-style downstream port. Only one access is in flight at a
// time. A stall watchdog aborts a transaction that stays stalled too long.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 8
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  // instruction-fetch requester
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic        imem_c_en,
  input  logic        imem_w_en,
  input  logic [3:0]  imem_b_en,
  output logic [31:0] imem_rdata,
  output logic        imem_error,
  output logic        imem_stall,
  // load/store requester
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_c_en,
  input  logic        dmem_w_en,
  input  logic [3:0]  dmem_b_en,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic        dmem_stall,
  // downstream port
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_c_en,
  output logic        mem_w_en,
  output logic [3:0]  mem_b_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  input  logic        mem_stall,
  // status
  output logic        busy,
  output logic        timeout_flag
);

  typedef enum logic {IDLE, BUSY} state_e;

  // Watchdog count at which a still-stalled access is aborted.
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;          // 0 = imem, 1 = dmem
  logic          last_grant_q, last_grant_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_flag_q, timeout_flag_d;

  logic          in_busy;
  logic          abort;
  logic          own_c_en;
  logic          own_w_en;
  logic [31:0]   own_addr;
  logic [31:0]   own_wdata;
  logic [3:0]    own_b_en;

  assign busy         = in_busy;
  assign timeout_flag = timeout_flag_q;

  // Select the current owner's live request and detect the watchdog abort.
  always_comb begin
    in_busy   = (state_q == BUSY);
    own_c_en  = owner_q ? dmem_c_en  : imem_c_en;
    own_w_en  = owner_q ? dmem_w_en  : imem_w_en;
    own_addr  = owner_q ? dmem_addr  : imem_addr;
    own_wdata = owner_q ? dmem_wdata : imem_wdata;
    own_b_en  = owner_q ? dmem_b_en  : imem_b_en;
    // A dropped request is not aborted; it simply ends without an error.
    abort     = in_busy && own_c_en && mem_stall &&
                (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);
  end

  // Downstream mux and per-requester responses.
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_c_en   = 1'b0;
    mem_w_en   = 1'b0;
    mem_b_en   = '0;
    imem_stall = imem_c_en;
    imem_rdata = '0;
    imem_error = 1'b0;
    dmem_stall = dmem_c_en;
    dmem_rdata = '0;
    dmem_error = 1'b0;
    if (in_busy) begin
      mem_addr  = own_addr;
      mem_wdata = own_wdata;
      mem_c_en  = own_c_en & ~abort;
      mem_w_en  = own_w_en;
      mem_b_en  = own_b_en;
      if (owner_q) begin
        dmem_stall = mem_stall & ~abort;
        dmem_rdata = abort ? '0 : mem_rdata;
        dmem_error = mem_error | abort;
      end else begin
        imem_stall = mem_stall & ~abort;
        imem_rdata = abort ? '0 : mem_rdata;
        imem_error = mem_error | abort;
      end
    end
  end

  // Next-state: grant in IDLE, finish on completion/drop/abort in BUSY.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    wd_cnt_d       = wd_cnt_q;
    timeout_flag_d = timeout_flag_q;
    unique case (state_q)
      IDLE: begin
        if (imem_c_en || dmem_c_en) begin
          state_d      = BUSY;
          owner_d      = (imem_c_en && dmem_c_en) ? ~last_grant_q : dmem_c_en;
          last_grant_d = owner_d;
          wd_cnt_d     = '0;
        end
      end
      BUSY: begin
        if (mem_stall && (wd_cnt_q != '1)) begin
          wd_cnt_d = wd_cnt_q + TW'(1);
        end
        // Completion needs mem_stall low and abort needs it high, so they
        // can never coincide; completion therefore always wins.
        if (!own_c_en || !mem_stall) begin
          state_d = IDLE;
        end else if (abort) begin
          state_d        = IDLE;
          timeout_flag_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      wd_cnt_q       <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      wd_cnt_q       <= wd_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: randomized two-port traffic
// against a transaction-level model, plus directed drop and reset cases.
module tb_mem_port_arbiter;

  localparam int unsigned TIMEOUT = 4;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] imem_addr, imem_wdata, imem_rdata;
  logic        imem_c_en, imem_w_en, imem_error, imem_stall;
  logic [3:0]  imem_b_en;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_c_en, dmem_w_en, dmem_error, dmem_stall;
  logic [3:0]  dmem_b_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_c_en, mem_w_en, mem_error, mem_stall;
  logic [3:0]  mem_b_en;
  logic        busy, timeout_flag;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .TW(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_c_en(imem_c_en),
    .imem_w_en(imem_w_en), .imem_b_en(imem_b_en), .imem_rdata(imem_rdata),
    .imem_error(imem_error), .imem_stall(imem_stall),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_c_en(dmem_c_en),
    .dmem_w_en(dmem_w_en), .dmem_b_en(dmem_b_en), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error), .dmem_stall(dmem_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_c_en(mem_c_en),
    .mem_w_en(mem_w_en), .mem_b_en(mem_b_en), .mem_rdata(mem_rdata),
    .mem_error(mem_error), .mem_stall(mem_stall),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected completion of one request.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Downstream responses keyed by (unique) request address.
  int unsigned rsp_n[logic [31:0]];
  logic [31:0] rsp_data[logic [31:0]];
  logic        rsp_err[logic [31:0]];

  logic mon_en    = 1'b0;
  logic rand_done = 1'b0;

  task automatic drive(input int p, input logic c, input logic [31:0] a,
                       input logic [31:0] wd, input logic w, input logic [3:0] be);
    if (p == 0) begin
      imem_c_en = c; imem_addr = a; imem_wdata = wd; imem_w_en = w; imem_b_en = be;
    end else begin
      dmem_c_en = c; dmem_addr = a; dmem_wdata = wd; dmem_w_en = w; dmem_b_en = be;
    end
  endtask

  // One requester: issues n requests with random gaps, holds each until done.
  task automatic requester(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a, wd, rd;
      logic        w, er, done;
      logic [3:0]  be;
      int unsigned ns;
      exp_t        e;
      repeat ($urandom_range(0, 2)) begin
        @(posedge ACLK); #1;
      end
      a  = (p == 0 ? 32'h1000_0000 : 32'h2000_0000) | (32'(k) << 2);
      wd = $urandom;
      rd = $urandom;
      w  = 1'($urandom);
      be = 4'($urandom);
      er = ($urandom_range(0, 3) == 0);
      ns = (p == 1 && k < 2) ? 32'(3 + k) : $urandom_range(0, 6);
      rsp_n[a]    = ns;
      rsp_data[a] = rd;
      rsp_err[a]  = er;
      // Stalled for ns cycles; aborted on BUSY cycle TIMEOUT if ns >= TIMEOUT.
      e.to    = (ns >= TIMEOUT);
      e.rdata = e.to ? 32'h0 : rd;
      e.err   = e.to ? 1'b1 : er;
      if (p == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      drive(p, 1'b1, a, wd, w, be);
      done = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge ACLK);
        if (p == 0 ? !imem_stall : !dmem_stall) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) chk(p == 0 ? "imem_req_timeout" : "dmem_req_timeout", 64'd0, 64'd1);
      @(posedge ACLK); #1;
      drive(p, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    end
  endtask

  // Downstream memory model: stalls each access for its scheduled count.
  initial begin
    int unsigned cnt;
    logic        bprev;
    logic [31:0] a;
    cnt = 0;
    bprev = 1'b0;
    mem_stall = 1'b0; mem_rdata = '0; mem_error = 1'b0;
    while (!rand_done) begin
      @(posedge ACLK); #1;
      if (rand_done) break;
      if (busy) begin
        cnt = bprev ? cnt + 1 : 0;
        a = mem_addr;
        if (rsp_n.exists(a)) begin
          mem_stall = (cnt < rsp_n[a]);
          mem_rdata = mem_stall ? $urandom : rsp_data[a];
          mem_error = mem_stall ? 1'($urandom) : rsp_err[a];
        end else begin
          mem_stall = 1'b0; mem_rdata = $urandom; mem_error = 1'b0;
        end
      end else begin
        mem_stall = 1'b0; mem_rdata = $urandom; mem_error = 1'($urandom);
      end
      bprev = busy;
    end
  end

  // Monitor model state.
  logic m_busy_prev, m_req_i, m_req_d, m_last, m_owner, m_end_prev, m_flag, m_set_flag, m_fin;

  task automatic complete(input int p, input logic [31:0] rd, input logic er);
    exp_t e;
    if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      chk(p == 0 ? "imem_unexpected_completion" : "dmem_unexpected_completion", 64'd1, 64'd0);
    end else begin
      e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk(p == 0 ? "imem_rdata" : "dmem_rdata", rd, e.rdata);
      chk(p == 0 ? "imem_error" : "dmem_error", er, e.err);
      if (e.to) m_set_flag = 1'b1;
    end
  endtask

  // Scoreboard monitor: grants, completions, non-owner responses, flag.
  always @(negedge ACLK) begin
    if (!mon_en) begin
      m_busy_prev = 1'b0; m_req_i = 1'b0; m_req_d = 1'b0; m_last = 1'b1;
      m_owner = 1'b0; m_end_prev = 1'b0; m_flag = 1'b0;
    end else begin
      m_set_flag = 1'b0;
      m_fin      = 1'b0;
      if (m_end_prev) chk("bubble_busy", busy, 1'b0);
      else if (!m_busy_prev) chk("idle_grant", busy, m_req_i | m_req_d);
      if (busy && !m_busy_prev) begin
        m_owner = (m_req_i && m_req_d) ? ~m_last : m_req_d;
        m_last  = m_owner;
        chk("grant_owner", mem_addr[29], m_owner);
        chk("grant_addr", mem_addr, m_owner ? dmem_addr : imem_addr);
        chk("grant_ctl", {mem_wdata, mem_w_en, mem_b_en},
            m_owner ? {dmem_wdata, dmem_w_en, dmem_b_en} : {imem_wdata, imem_w_en, imem_b_en});
        chk("grant_cen", mem_c_en, 1'b1);
      end
      if (busy && m_owner == 1'b0) begin
        if (imem_c_en && !imem_stall) begin
          complete(0, imem_rdata, imem_error);
          m_fin = 1'b1;
        end
      end else begin
        chk("imem_nonowner", {imem_stall, imem_error, imem_rdata}, {imem_c_en, 1'b0, 32'h0});
      end
      if (busy && m_owner == 1'b1) begin
        if (dmem_c_en && !dmem_stall) begin
          complete(1, dmem_rdata, dmem_error);
          m_fin = 1'b1;
        end
      end else begin
        chk("dmem_nonowner", {dmem_stall, dmem_error, dmem_rdata}, {dmem_c_en, 1'b0, 32'h0});
      end
      chk("timeout_flag", timeout_flag, m_flag);
      if (m_set_flag) m_flag = 1'b1;
      m_end_prev  = m_fin;
      m_busy_prev = busy;
      m_req_i     = imem_c_en;
      m_req_d     = dmem_c_en;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    ARESETn = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    repeat (2) @(negedge ACLK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem", {mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en}, '0);
    chk("rst_flag", timeout_flag, 1'b0);
    chk("rst_stalls", {imem_stall, dmem_stall}, 2'b00);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    mon_en  = 1'b1;

    fork
      requester(0, 30);
      requester(1, 30);
    join
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    mon_en    = 1'b0;
    rand_done = 1'b1;
    chk("imem_sb_empty", exp_q0.size(), 0);
    chk("dmem_sb_empty", exp_q1.size(), 0);
    chk("flag_sticky", timeout_flag, 1'b1);
    @(posedge ACLK); #2;

    // Owner drops its request mid-transaction.
    mem_stall = 1'b1; mem_rdata = 32'hDEAD_0000; mem_error = 1'b0;
    drive(1, 1'b1, 32'h300, 32'hA5, 1'b1, 4'hF);
    @(negedge ACLK);
    chk("drop_idle_busy", busy, 1'b0);
    chk("drop_idle_stall", dmem_stall, 1'b1);
    @(posedge ACLK); #1;
    chk("drop_busy", {busy, mem_c_en, mem_addr}, {1'b1, 1'b1, 32'h300});
    @(posedge ACLK); #1;
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    #1;
    chk("drop_cen_follow", {busy, mem_c_en}, {1'b1, 1'b0});
    @(posedge ACLK); #1;
    chk("drop_to_idle", busy, 1'b0);
    chk("drop_flag_kept", timeout_flag, 1'b1);

    // Asynchronous reset during a stalled dmem access.
    drive(1, 1'b1, 32'h400, 32'h0, 1'b0, 4'hF);
    @(posedge ACLK); #1;
    chk("arst_pre_busy", {busy, mem_c_en}, {1'b1, 1'b1});
    #2;
    ARESETn = 1'b0;
    #1;
    chk("arst_now", {busy, mem_c_en, mem_addr}, {1'b0, 1'b0, 32'h0});
    chk("arst_flag", timeout_flag, 1'b0);
    drive(0, 1'b1, 32'h500, 32'h0, 1'b0, 4'hF);
    @(posedge ACLK); #3;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("arst_tie_imem", {busy, mem_addr}, {1'b1, 32'h500});
    chk("arst_dmem_wait", dmem_stall, 1'b1);
    mem_stall = 1'b0; mem_rdata = 32'hDEADBEEF; mem_error = 1'b0;
    #1;
    chk("arst_fetch_done", {imem_stall, imem_error, imem_rdata}, {1'b0, 1'b0, 32'hDEADBEEF});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
